// File: rtl/pp_pipeline_accel_arb_pkg.sv
// rtl/pp_pipeline_accel_arb_pkg.sv - shared encodings and defaults for the two-source FIFO arbiter
package pp_pipeline_accel_arb_pkg;

    // State encoding doubles as the one-hot grant output.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GNT0 = 2'b01,
        ST_GNT1 = 2'b10
    } state_t;

    localparam int BURST_DEFAULT     = 4;
    localparam int CNT_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/pp_pipeline_accel_fifo_arb2.sv
// rtl/pp_pipeline_accel_fifo_arb2.sv - round-robin burst arbiter moving words from two source FIFOs into one sink FIFO
module pp_pipeline_accel_fifo_arb2
    import pp_pipeline_accel_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 11,
    parameter int BURST      = BURST_DEFAULT,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  s0_empty_n,
    output logic                  s0_read,
    input  logic [DATA_WIDTH-1:0] s0_dout,
    input  logic                  s1_empty_n,
    output logic                  s1_read,
    input  logic [DATA_WIDTH-1:0] s1_dout,
    input  logic                  m_full_n,
    output logic                  m_write,
    output logic [DATA_WIDTH-1:0] m_din,
    output logic [1:0]            grant,
    output logic [CNT_WIDTH-1:0]  cnt0,
    output logic [CNT_WIDTH-1:0]  cnt1
);

    // Burst count value at which the current fire is the last one of the grant.
    localparam logic [7:0] BURST_LAST = 8'(BURST - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_last;       // last served source: 0 or 1
    logic                 w_next_last;
    logic                 r_armed;      // delays the first grant by one edge after reset release
    logic [7:0]           r_burst;
    logic [CNT_WIDTH-1:0] r_cnt0;
    logic [CNT_WIDTH-1:0] r_cnt1;
    logic                 w_fire0;
    logic                 w_fire1;
    logic                 w_enter;

    // A word moves only when the owner has data, the sink has room and arbitration is enabled.
    always_comb begin
        w_fire0 = (r_state == ST_GNT0) && enable && s0_empty_n && m_full_n;
        w_fire1 = (r_state == ST_GNT1) && enable && s1_empty_n && m_full_n;
    end

    // Next-state: round robin from IDLE, hand-over or release when a grant ends.
    always_comb begin
        w_next_state = r_state;
        w_next_last  = r_last;
        w_enter      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_armed && enable && (s0_empty_n || s1_empty_n)) begin
                    w_enter = 1'b1;
                    if (s0_empty_n && s1_empty_n) begin
                        w_next_state = r_last ? ST_GNT0 : ST_GNT1;
                    end else if (s0_empty_n) begin
                        w_next_state = ST_GNT0;
                    end else begin
                        w_next_state = ST_GNT1;
                    end
                end
            end
            ST_GNT0: begin
                if (!enable || !s0_empty_n || (w_fire0 && (r_burst == BURST_LAST))) begin
                    w_next_last = 1'b0;
                    if (enable && s1_empty_n) begin
                        w_next_state = ST_GNT1;
                        w_enter      = 1'b1;
                    end else if (enable && s0_empty_n) begin
                        w_next_state = ST_GNT0;
                        w_enter      = 1'b1;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            ST_GNT1: begin
                if (!enable || !s1_empty_n || (w_fire1 && (r_burst == BURST_LAST))) begin
                    w_next_last = 1'b1;
                    if (enable && s0_empty_n) begin
                        w_next_state = ST_GNT0;
                        w_enter      = 1'b1;
                    end else if (enable && s1_empty_n) begin
                        w_next_state = ST_GNT1;
                        w_enter      = 1'b1;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, round-robin pointer and arming flag; last=1 makes source 0 first after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_last  <= w_next_last;
            r_armed <= 1'b1;
        end
    end

    // Burst counter restarts on every grant entry and counts fires within the grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_burst <= 8'd0;
        end else if (w_enter) begin
            r_burst <= 8'd0;
        end else if (w_fire0 || w_fire1) begin
            r_burst <= r_burst + 8'd1;
        end
    end

    // Per-source forwarded-word counters, free-running with natural wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_fire0) begin
                r_cnt0 <= r_cnt0 + CNT_WIDTH'(1);
            end
            if (w_fire1) begin
                r_cnt1 <= r_cnt1 + CNT_WIDTH'(1);
            end
        end
    end

    // Zero-latency pass-through of the owner's head word; idle drives zero.
    always_comb begin
        case (r_state)
            ST_GNT0: m_din = s0_dout;
            ST_GNT1: m_din = s1_dout;
            default: m_din = '0;
        endcase
    end

    assign s0_read = w_fire0;
    assign s1_read = w_fire1;
    assign m_write = w_fire0 || w_fire1;
    assign grant   = 2'(r_state);
    assign cnt0    = r_cnt0;
    assign cnt1    = r_cnt1;

endmodule

// File: tb/tb_pp_pipeline_accel_fifo_arb2.sv
// tb/tb_pp_pipeline_accel_fifo_arb2.sv - directed self-checking bench for the two-source FIFO arbiter
module tb_pp_pipeline_accel_fifo_arb2;

    localparam int DW = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          s0_empty_n, s1_empty_n, m_full_n;
    logic [DW-1:0] s0_dout, s1_dout, m_din, b_m_din;
    logic          s0_read, s1_read, m_write;
    logic          b_s0_read, b_s1_read, b_m_write;
    logic [1:0]    grant, b_grant;
    logic [15:0]   cnt0, cnt1;
    logic [3:0]    b_cnt0, b_cnt1;

    always #5 clk = ~clk;

    pp_pipeline_accel_fifo_arb2 #(.DATA_WIDTH(DW), .BURST(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .s0_empty_n(s0_empty_n), .s0_read(s0_read), .s0_dout(s0_dout),
        .s1_empty_n(s1_empty_n), .s1_read(s1_read), .s1_dout(s1_dout),
        .m_full_n(m_full_n), .m_write(m_write), .m_din(m_din),
        .grant(grant), .cnt0(cnt0), .cnt1(cnt1)
    );

    pp_pipeline_accel_fifo_arb2 #(.DATA_WIDTH(DW), .BURST(4), .CNT_WIDTH(4)) dut_small (
        .clk(clk), .reset(reset), .enable(enable),
        .s0_empty_n(s0_empty_n), .s0_read(b_s0_read), .s0_dout(s0_dout),
        .s1_empty_n(s1_empty_n), .s1_read(b_s1_read), .s1_dout(s1_dout),
        .m_full_n(m_full_n), .m_write(b_m_write), .m_din(b_m_din),
        .grant(b_grant), .cnt0(b_cnt0), .cnt1(b_cnt1)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] q0[$], q1[$], sink[$];
    logic [1:0]    gl[$];
    int            fire_cyc[$];
    int            cyc;
    bit            viol = 1'b0;
    logic          s_rd0, s_rd1, s_wr;
    logic [DW-1:0] s_din;
    logic [1:0]    s_g;

    logic [DW-1:0] exp_a[16] = '{11'h100, 11'h101, 11'h102, 11'h103, 11'h200, 11'h201, 11'h202, 11'h203,
                                 11'h104, 11'h105, 11'h106, 11'h107, 11'h204, 11'h205, 11'h206, 11'h207};
    logic [1:0]    exp_ag[16] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2,
                                  2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
    logic [DW-1:0] exp_c[8] = '{11'h100, 11'h101, 11'h102, 11'h103, 11'h200, 11'h201, 11'h104, 11'h105};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: present FIFO heads, sample outputs mid-cycle, pop after the edge.
    task automatic tick();
        s0_empty_n = (q0.size() != 0);
        s0_dout    = (q0.size() != 0) ? q0[0] : '0;
        s1_empty_n = (q1.size() != 0);
        s1_dout    = (q1.size() != 0) ? q1[0] : '0;
        #2;
        s_rd0 = s0_read;
        s_rd1 = s1_read;
        s_wr  = m_write;
        s_din = m_din;
        s_g   = grant;
        if ((s_rd0 && s_rd1) || (s_wr != (s_rd0 || s_rd1)) || (b_m_write != s_wr)) viol = 1'b1;
        if (s_wr) begin
            sink.push_back(s_din);
            gl.push_back(s_g);
            fire_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        if (s_rd0) void'(q0.pop_front());
        if (s_rd1) void'(q1.pop_front());
        cyc++;
    endtask

    task automatic run_fires(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && sink.size() < n; i++) tick();
        check(tag, sink.size(), n);
    endtask

    task automatic run_idle(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (q0.size() == 0 && q1.size() == 0 && grant == 2'b00) break;
            tick();
        end
        check(tag, grant, 2'b00);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q0.delete(); q1.delete(); sink.delete(); gl.delete(); fire_cyc.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    function automatic logic [31:0] sink_at(input int i);
        return (i < sink.size()) ? 32'(sink[i]) : 32'hffff_ffff;
    endfunction

    initial begin
        int stall_pulses;
        bit held;
        reset = 1'b1; enable = 1'b1; m_full_n = 1'b1;
        s0_empty_n = 1'b0; s1_empty_n = 1'b0; s0_dout = '0; s1_dout = '0;
        #3;
        check("rst_grant", grant, 2'b00);
        check("rst_write", m_write, 1'b0);
        check("rst_din", m_din, 0);
        check("rst_cnt0", cnt0, 0);
        check("rst_cnt1", cnt1, 0);

        // Both sources hold 8 words: alternating bursts of 4, source 0 first.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            q0.push_back(DW'(11'h100 + k));
            q1.push_back(DW'(11'h200 + k));
        end
        tick(); check("a_rel_edge1", s_g, 2'b00);
        tick(); check("a_rel_edge2", s_g, 2'b00);
        tick(); check("a_first_grant", s_g, 2'b01); check("a_first_write", s_wr, 1'b1);
        run_fires(16, 60, "a_fire_count");
        run_idle(10, "a_drain");
        for (int i = 0; i < 16; i++) begin
            check($sformatf("a_din%0d", i), sink_at(i), exp_a[i]);
            check($sformatf("a_gnt%0d", i), (i < gl.size()) ? 32'(gl[i]) : 32'hf, exp_ag[i]);
        end
        check("a_cnt0", cnt0, 8);
        check("a_cnt1", cnt1, 8);
        check("a_small_cnt0", b_cnt0, 8);

        // Only source 1 holds 3 words: back-to-back fires, then idle.
        do_reset();
        q1.push_back(11'h300); q1.push_back(11'h301); q1.push_back(11'h302);
        run_fires(3, 20, "b_fire_count");
        run_idle(10, "b_drain");
        check("b_total", sink.size(), 3);
        check("b_din0", sink_at(0), 11'h300);
        check("b_din2", sink_at(2), 11'h302);
        check("b_gnt", (gl.size() > 0) ? 32'(gl[0]) : 32'hf, 2'b10);
        check("b_b2b", (fire_cyc.size() == 3) ? fire_cyc[2] - fire_cyc[0] : -1, 2);
        check("b_cnt1", cnt1, 3);
        check("b_cnt0", cnt0, 0);

        // Sink full for 5 cycles after 2 fires: grant held, burst resumes with 2 left.
        do_reset();
        for (int k = 0; k < 6; k++) q0.push_back(DW'(11'h100 + k));
        q1.push_back(11'h200); q1.push_back(11'h201);
        run_fires(2, 20, "c_pre");
        m_full_n = 1'b0;
        stall_pulses = 0;
        held = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            stall_pulses += int'(s_rd0) + int'(s_rd1) + int'(s_wr);
            if (s_g != 2'b01) held = 1'b0;
        end
        m_full_n = 1'b1;
        check("c_stall_pulses", stall_pulses, 0);
        check("c_stall_grant", held, 1'b1);
        run_fires(8, 60, "c_fire_count");
        run_idle(10, "c_drain");
        for (int i = 0; i < 8; i++) check($sformatf("c_din%0d", i), sink_at(i), exp_c[i]);

        // Enable dropped after 2 fires: no fire, idle, then the other source first.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            q0.push_back(DW'(11'h100 + k));
            q1.push_back(DW'(11'h200 + k));
        end
        run_fires(2, 20, "d_pre");
        enable = 1'b0;
        tick();
        check("d_nofire", s_wr, 1'b0);
        check("d_grant_held", s_g, 2'b01);
        check("d_idle", grant, 2'b00);
        enable = 1'b1;
        tick(); check("d_reen_idle", s_g, 2'b00);
        tick(); check("d_other_grant", s_g, 2'b10); check("d_other_din", s_din, 11'h200);

        // Reset pulsed between edges mid-burst.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            q0.push_back(DW'(11'h100 + k));
            q1.push_back(DW'(11'h200 + k));
        end
        run_fires(1, 20, "e_pre");
        s0_empty_n = 1'b1; s0_dout = q0[0];
        s1_empty_n = 1'b1; s1_dout = q1[0];
        #2;
        check("e_pre_write", m_write, 1'b1);
        reset = 1'b1;
        #1;
        check("e_write", m_write, 1'b0);
        check("e_read0", s0_read, 1'b0);
        check("e_grant", grant, 2'b00);
        check("e_din", m_din, 0);
        check("e_cnt0", cnt0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("e_q0_kept", q0.size(), 3);
        sink.delete(); gl.delete(); fire_cyc.delete();
        run_fires(1, 20, "e_after");
        check("e_after_grant", (gl.size() > 0) ? 32'(gl[0]) : 32'hf, 2'b01);
        check("e_after_din", sink_at(0), 11'h101);

        // 17 fires from source 0 into a 4-bit counter: 15, wrap to 0, then 1.
        do_reset();
        for (int k = 0; k < 17; k++) q0.push_back(DW'(k));
        run_fires(15, 40, "f_15");
        check("f_cnt15", b_cnt0, 4'd15);
        run_fires(16, 10, "f_16");
        check("f_wrap0", b_cnt0, 4'd0);
        run_fires(17, 10, "f_17");
        check("f_wrap1", b_cnt0, 4'd1);
        check("f_wide_cnt0", cnt0, 17);

        check("excl_and_write_consistency", viol, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
